// File: rtl/freq_spi_loader.sv
// freq_spi_loader
//   Loads one frequency word from the LUT and writes it to the RF synthesiser
//   as two 16-bit mode-0 SPI frames: FreqData[31:16] first, then FreqData[15:0].
//   Each frame is sent MSB first.
//
//   Ports
//     clk, rstn           clock, synchronous active-low reset
//     start, freq_num_in  load request and channel index (sampled when idle)
//     FreqNum             registered channel index to the LUT
//     FreqData            LUT word, sampled at the end of the 2-cycle LUT wait
//     busy, done          transfer in progress / one-cycle completion pulse
//     spi_cs_n, spi_sclk, spi_mosi  SPI pins (sclk idles low)
//
//   Optional feature macro: FREQ_LOADER_SKIP_SAME_EN
//     When this macro is defined, a request for the channel index that was
//     last loaded successfully completes without SPI traffic.
module freq_spi_loader #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [4:0]  freq_num_in,
  output logic [4:0]  FreqNum,
  input  logic [31:0] FreqData,
  output logic        busy,
  output logic        done,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  // The divider also times the LUT wait, so it needs to be able to hold 1.
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP  > 2) ? $clog2(CS_GAP)  : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LUT   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
`ifdef FREQ_LOADER_SKIP_SAME_EN
  localparam logic [2:0] S_SKIP  = 3'd4;
  logic [4:0] last_num;
  logic       last_valid;
`endif

  logic [2:0]    state;
  logic [DW-1:0] div;
  logic [GW-1:0] gap;
  logic [3:0]    bit_cnt;
  logic          frame;
  // The whole word shifts left through both frames; after frame0 the low
  // half sits in the top bits, so mosi always comes from sh[31].
  logic [31:0]   sh;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      FreqNum  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      div      <= '0;
      gap      <= '0;
      bit_cnt  <= '0;
      frame    <= 1'b0;
      sh       <= '0;
`ifdef FREQ_LOADER_SKIP_SAME_EN
      last_num   <= '0;
      last_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            FreqNum <= freq_num_in;
            busy    <= 1'b1;
            div     <= '0;
`ifdef FREQ_LOADER_SKIP_SAME_EN
            if (last_valid && (freq_num_in == last_num)) state <= S_SKIP;
            else                                         state <= S_LUT;
`else
            state <= S_LUT;
`endif
          end
        end
`ifdef FREQ_LOADER_SKIP_SAME_EN
        S_SKIP: begin
          busy       <= 1'b0;
          done       <= 1'b1;
          last_valid <= 1'b1;
          last_num   <= FreqNum;
          state      <= S_IDLE;
        end
`endif
        S_LUT: begin
          if (div == DW'(1)) begin
            div      <= '0;
            sh       <= FreqData;
            frame    <= 1'b0;
            bit_cnt  <= '0;
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= FreqData[31];
            state    <= S_SHIFT;
          end else begin
            div <= div + 1'b1;
          end
        end
        S_SHIFT: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              // End of a high phase: next bit (or end of frame) starts low.
              spi_sclk <= 1'b0;
              sh       <= sh << 1;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd15) begin
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                gap      <= '0;
                state    <= S_GAP;
              end else begin
                spi_mosi <= sh[30];
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_GAP: begin
          if (gap == GAP_LAST) begin
            gap <= '0;
            if (!frame) begin
              frame    <= 1'b1;
              spi_cs_n <= 1'b0;
              spi_mosi <= sh[31];
              state    <= S_SHIFT;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
`ifdef FREQ_LOADER_SKIP_SAME_EN
              last_valid <= 1'b1;
              last_num   <= FreqNum;
`endif
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_spi_loader.sv
// Scoreboard bench for freq_spi_loader: stimulus pushes expected SPI frames
// and completion records; a monitor decodes the SPI pins and done pulses.
module tb_freq_spi_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [4:0]  freq_num_in;
  logic [4:0]  FreqNum;
  logic [31:0] FreqData;
  logic        busy, done, spi_cs_n, spi_sclk, spi_mosi;

  freq_spi_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .freq_num_in(freq_num_in),
    .FreqNum(FreqNum), .FreqData(FreqData), .busy(busy), .done(done),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi)
  );

  always #5 clk = ~clk;

  // Registered LUT model.
  function automatic logic [31:0] lut(input logic [4:0] n);
    case (n)
      5'd0:    return 32'h0C00_0D3C;
      5'd5:    return 32'h0CF0_0D3C;
      5'd9:    return 32'h0CB0_0D3D;
      5'd10:   return 32'h0CE0_0D3D;
      5'h16:   return 32'h0C20_0D40;
      5'h1F:   return 32'h0CD0_0D41;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction
  always @(posedge clk) FreqData <= lut(FreqNum);

  typedef struct { int lat; int rises; } exp_t;
  exp_t        xq[$];
  logic [15:0] fq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_full(input logic [15:0] f0, input logic [15:0] f1);
    exp_t e;
    e.lat = 267; e.rises = 32;
    xq.push_back(e);
    fq.push_back(f0);
    fq.push_back(f1);
  endtask

  task automatic push_skip();
    exp_t e;
    e.lat = 2; e.rises = 0;
    xq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic [15:0] m_sh;
  int   m_bits, m_rises, m_acc, m_cs_hi;
  logic prev_sclk, prev_busy, prev_cs, prev_mosi;

  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      m_bits = 0; m_rises = 0; m_cs_hi = 0; m_acc = 0;
      prev_sclk = 1'b0; prev_busy = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        m_acc   = cyc - 1;
        m_rises = 0;
      end
      if (spi_sclk && !prev_sclk) begin
        chk("cs_low_at_rise", {31'd0, spi_cs_n}, 32'd0);
        chk("mosi_stable_low_phase", {31'd0, spi_mosi}, {31'd0, prev_mosi});
        m_sh = {m_sh[14:0], spi_mosi};
        m_bits++;
        m_rises++;
        if (m_bits == 16) begin
          m_bits = 0;
          if (fq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL frame_unexpected: got %0h expected none", m_sh);
          end else begin
            chk("frame", {16'd0, m_sh}, {16'd0, fq.pop_front()});
          end
        end
      end
      if (spi_cs_n) m_cs_hi++;
      else begin
        if (prev_cs && m_rises == 16) chk("cs_gap", m_cs_hi, 4);
        m_cs_hi = 0;
      end
      if (done) begin
        if (xq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done_unexpected: got done expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = xq.pop_front();
          chk("latency", cyc - m_acc, e.lat);
          chk("sclk_rises", m_rises, e.rises);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      prev_sclk = spi_sclk; prev_busy = busy; prev_cs = spi_cs_n; prev_mosi = spi_mosi;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [4:0] n);
    @(posedge clk); #1;
    start = 1'b1; freq_num_in = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    n_chk++; n_fail++;
    $display("FAIL done_timeout: got no done expected done within 3000 cycles");
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; freq_num_in = 5'd0;
    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_freqnum", {27'd0, FreqNum}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // 2: basic load
    push_full(16'h0CF0, 16'h0D3C);
    issue(5'd5);
    @(negedge clk);
    chk("freqnum_5", {27'd0, FreqNum}, 32'd5);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done();

    // 3: second start mid-frame0 is ignored
    push_full(16'h0C20, 16'h0D40);
    issue(5'h16);
    repeat (40) @(posedge clk);
    #1 start = 1'b1; freq_num_in = 5'd3;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("freqnum_held", {27'd0, FreqNum}, 32'h16);
    wait_done();
    repeat (10) @(negedge clk);
    chk("idle_after_ignored", {31'd0, busy}, 32'd0);

    // 4: reset during bit 7 of frame1, then a fresh load
    fq.push_back(16'h0CF0);
    issue(5'd5);
    repeat (193) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    push_full(16'h0CD0, 16'h0D41);
    issue(5'h1F);
    wait_done();

    // 5: start held high -> back-to-back loads
    push_full(16'h0C00, 16'h0D3C);
`ifdef FREQ_LOADER_SKIP_SAME_EN
    push_skip();
`else
    push_full(16'h0C00, 16'h0D3C);
`endif
    @(posedge clk); #1 start = 1'b1; freq_num_in = 5'd0;
    wait_done();
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_freqnum", {27'd0, FreqNum}, 32'd0);
    wait_done();

    // 6: repeat of the same channel, then a new one
    push_full(16'h0CB0, 16'h0D3D);
    issue(5'd9);
    wait_done();
`ifdef FREQ_LOADER_SKIP_SAME_EN
    push_skip();
`else
    push_full(16'h0CB0, 16'h0D3D);
`endif
    issue(5'd9);
    wait_done();
    push_full(16'h0CE0, 16'h0D3D);
    issue(5'd10);
    wait_done();

    repeat (20) @(negedge clk);
    chk("pending_done", xq.size(), 0);
    chk("pending_frames", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
